// File: rtl/alu_exec_unit_pkg.sv
// alu_exec_unit_pkg: shared constants for the execute-stage ALU.
//   - 3-bit ALU control codes (ALU_*)
//   - 2-bit main-control ALUop encodings (ALUOP_*)
//   - 6-bit R-type funct encodings (FUNCT_*)
// Optional feature macro: ALU_EXT_OPS_EN (XOR/NOR codes are always declared).
package alu_exec_unit_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;  // lw/sw/addi -> add
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;  // beq -> sub
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;  // decode funct
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;  // unused -> add, not illegal

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_XOR = 6'b100110;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: operand/control bus into the execute stage and its results.
//   master: drives en, ALUop, funct, A, B, branch; observes all results.
//   slave : the execute unit (consumes inputs, drives results).
interface alu_exec_unit_if #(parameter int WIDTH = 32);
  logic             en;
  logic [1:0]       ALUop;
  logic [5:0]       funct;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             branch;
  logic [2:0]       ALU_control;
  logic [WIDTH-1:0] ALU_result;
  logic             zero;
  logic             pc_src;
  logic             illegal;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             pc_src_q;

  modport master (
    output en, ALUop, funct, A, B, branch,
    input  ALU_control, ALU_result, zero, pc_src, illegal, result_q, zero_q, pc_src_q
  );
  modport slave (
    input  en, ALUop, funct, A, B, branch,
    output ALU_control, ALU_result, zero, pc_src, illegal, result_q, zero_q, pc_src_q
  );
endinterface

// File: rtl/alu_exec_unit_decoder.sv
// alu_decoder: combinational ALUop/funct -> 3-bit ALU control decode.
//   alu_op  in  2  main-control ALU opcode
//   funct   in  6  instruction[5:0]
//   ctrl    out 3  ALU control code
//   illegal out 1  R-type with unrecognised funct
// Feature macro ALU_EXT_OPS_EN adds XOR/NOR funct decodes.
module alu_decoder
  import alu_exec_unit_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] ctrl,
  output logic       illegal
);

  // funct is only looked at for R-type, so an undriven funct on
  // memory/branch ops can never leak into ctrl.
  always_comb begin
    ctrl    = ALU_ADD;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_BEQ: ctrl = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: ctrl = ALU_ADD;
          FUNCT_SUB: ctrl = ALU_SUB;
          FUNCT_AND: ctrl = ALU_AND;
          FUNCT_OR:  ctrl = ALU_OR;
          FUNCT_SLT: ctrl = ALU_SLT;
`ifdef ALU_EXT_OPS_EN
          FUNCT_XOR: ctrl = ALU_XOR;
          FUNCT_NOR: ctrl = ALU_NOR;
`endif
          default:   illegal = 1'b1;  // ctrl stays ADD
        endcase
      end
      default: ;  // ALUOP_MEM / ALUOP_RSVD -> add
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage datapath for the single-cycle MIPS core.
//   clock  in  system clock (rising edge)
//   reset  in  synchronous active-low reset, clears registered outputs only
//   bus    alu_exec_unit_if.slave: en/ALUop/funct/A/B/branch in;
//          ALU_control/ALU_result/zero/pc_src/illegal (combinational) and
//          result_q/zero_q/pc_src_q (registered, captured when en) out
// Feature macro ALU_EXT_OPS_EN enables XOR (011) and NOR (100).
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clock,
  input  logic          reset,
  alu_exec_unit_if.slave bus
);

  logic [2:0]       ctrl;
  logic [WIDTH-1:0] res;
  logic             zero;
  logic             pc_src;

  alu_decoder u_dec (
    .alu_op  (bus.ALUop),
    .funct   (bus.funct),
    .ctrl    (ctrl),
    .illegal (bus.illegal)
  );

  always_comb begin
    res = '0;
    case (ctrl)
      ALU_AND: res = bus.A & bus.B;
      ALU_OR:  res = bus.A | bus.B;
      ALU_ADD: res = bus.A + bus.B;
      ALU_SUB: res = bus.A - bus.B;
      ALU_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
`ifdef ALU_EXT_OPS_EN
      ALU_XOR: res = bus.A ^ bus.B;
      ALU_NOR: res = ~(bus.A | bus.B);
`endif
      default: res = '0;  // unassigned codes
    endcase
  end

  assign zero   = (res == '0);
  assign pc_src = bus.branch & zero;

  assign bus.ALU_control = ctrl;
  assign bus.ALU_result  = res;
  assign bus.zero        = zero;
  assign bus.pc_src      = pc_src;

  always_ff @(posedge clock) begin
    if (!reset) begin
      bus.result_q <= '0;
      bus.zero_q   <= 1'b0;
      bus.pc_src_q <= 1'b0;
    end else if (bus.en) begin
      bus.result_q <= res;
      bus.zero_q   <= zero;
      bus.pc_src_q <= pc_src;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed + randomized checks of alu_exec_unit against a
// behavioural reference model (operation named by opcode/funct, evaluated
// with plain arithmetic).
module tb_alu_exec_unit;
  import alu_exec_unit_pkg::*;

  localparam int WIDTH = 32;

  logic clock;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;

  alu_exec_unit_if #(.WIDTH(WIDTH)) bus ();

  alu_exec_unit #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // R-type funct -> operation name
  string rtype_op [logic [5:0]];

  // registered-output model state
  logic [WIDTH-1:0] m_res_q;
  logic             m_zero_q;
  logic             m_pc_q;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic void ref_model(input logic [1:0] op, input logic [5:0] f,
                                    input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    output logic [2:0] ctrl, output logic [WIDTH-1:0] res,
                                    output logic ill);
    string kind;
    ill = 1'b0;
    if (op == 2'b01) kind = "sub";
    else if (op == 2'b10) begin
      if (rtype_op.exists(f)) kind = rtype_op[f];
      else begin kind = "add"; ill = 1'b1; end
    end else kind = "add";
    if (kind == "add")      begin ctrl = 3'b010; res = a + b; end
    else if (kind == "sub") begin ctrl = 3'b110; res = a - b; end
    else if (kind == "and") begin ctrl = 3'b000; res = a & b; end
    else if (kind == "or")  begin ctrl = 3'b001; res = a | b; end
    else if (kind == "xor") begin ctrl = 3'b011; res = a ^ b; end
    else if (kind == "nor") begin ctrl = 3'b100; res = ~(a | b); end
    else begin
      ctrl = 3'b111;
      res  = (int'($signed(a)) < int'($signed(b))) ? 1 : 0;
    end
  endfunction

  task automatic drive(input logic [1:0] op, input logic [5:0] f,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic br);
    bus.ALUop = op; bus.funct = f; bus.A = a; bus.B = b; bus.branch = br;
  endtask

  // full combinational check against the model; returns model values
  task automatic check_comb(input string tag, output logic [WIDTH-1:0] e_res,
                            output logic e_zero, output logic e_pc);
    logic [2:0] e_ctrl;
    logic       e_ill;
    ref_model(bus.ALUop, bus.funct, bus.A, bus.B, e_ctrl, e_res, e_ill);
    e_zero = (e_res == 0);
    e_pc   = bus.branch & e_zero;
    chk({tag, ".ctrl"},    64'(bus.ALU_control), 64'(e_ctrl));
    chk({tag, ".result"},  64'(bus.ALU_result),  64'(e_res));
    chk({tag, ".zero"},    64'(bus.zero),        64'(e_zero));
    chk({tag, ".pc_src"},  64'(bus.pc_src),      64'(e_pc));
    chk({tag, ".illegal"}, 64'(bus.illegal),     64'(e_ill));
  endtask

  task automatic rop(input string tag, input logic [5:0] f, input logic [WIDTH-1:0] a,
                     input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp);
    drive(2'b10, f, a, b, 1'b0);
    #1 chk(tag, 64'(bus.ALU_result), 64'(exp));
  endtask

  logic [WIDTH-1:0] e_res;
  logic             e_zero, e_pc;
  logic [5:0]       fsel [8];

  initial begin
    rtype_op[6'b100000] = "add";
    rtype_op[6'b100010] = "sub";
    rtype_op[6'b100100] = "and";
    rtype_op[6'b100101] = "or";
    rtype_op[6'b101010] = "slt";
`ifdef ALU_EXT_OPS_EN
    rtype_op[6'b100110] = "xor";
    rtype_op[6'b100111] = "nor";
`endif
    fsel = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
             6'b101010, 6'b100110, 6'b100111, 6'b111111};

    // reset state
    reset = 1'b0; bus.en = 1'b1;
    drive(2'b00, 6'b0, 32'd1, 32'd2, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst.result_q", 64'(bus.result_q), 0);
    chk("rst.zero_q",   64'(bus.zero_q),   0);
    chk("rst.pc_src_q", 64'(bus.pc_src_q), 0);
    @(negedge clock);
    reset = 1'b1; bus.en = 1'b0;

    // decoder
    drive(2'b00, 6'bx, 32'd5, 32'd3, 1'b0);
    #1 chk("dec.op00", 64'(bus.ALU_control), 64'(3'b010));
    chk("dec.op00.result", 64'(bus.ALU_result), 8);
    drive(2'b01, 6'bx, 32'd5, 32'd3, 1'b0);
    #1 chk("dec.op01", 64'(bus.ALU_control), 64'(3'b110));
    drive(2'b10, 6'b100000, 32'd5, 32'd3, 1'b0);
    #1 chk("dec.add", 64'(bus.ALU_control), 64'(3'b010));
    drive(2'b10, 6'b101010, 32'd5, 32'd3, 1'b0);
    #1 chk("dec.slt", 64'(bus.ALU_control), 64'(3'b111));
    drive(2'b10, 6'b111111, 32'd5, 32'd3, 1'b0);
    #1 chk("dec.bad.ctrl", 64'(bus.ALU_control), 64'(3'b010));
    chk("dec.bad.illegal", 64'(bus.illegal), 1);
    drive(2'b11, 6'b111111, 32'd5, 32'd3, 1'b0);
    #1 chk("dec.op11.illegal", 64'(bus.illegal), 0);

    // ALU ops
    rop("alu.and", 6'b100100, 32'd5, 32'd3, 32'd1);
    rop("alu.or",  6'b100101, 32'd5, 32'd3, 32'd7);
    rop("alu.add", 6'b100000, 32'd5, 32'd3, 32'd8);
    rop("alu.sub", 6'b100010, 32'd5, 32'd3, 32'd2);
    rop("alu.slt", 6'b101010, 32'd5, 32'd3, 32'd0);
    rop("alu.slt.neg", 6'b101010, 32'hFFFF_FFFF, 32'd0, 32'd1);
    rop("wrap.add", 6'b100000, 32'hFFFF_FFFF, 32'd1, 32'd0);
    chk("wrap.add.zero", 64'(bus.zero), 1);
    rop("wrap.sub", 6'b100010, 32'd0, 32'd1, 32'hFFFF_FFFF);
`ifdef ALU_EXT_OPS_EN
    rop("ext.xor", 6'b100110, 32'd5, 32'd3, 32'd6);
    chk("ext.xor.illegal", 64'(bus.illegal), 0);
    rop("ext.nor", 6'b100111, 32'd5, 32'd3, 32'hFFFF_FFF8);
    chk("ext.nor.illegal", 64'(bus.illegal), 0);
`else
    rop("noext.xor", 6'b100110, 32'd5, 32'd3, 32'd8);
    chk("noext.xor.illegal", 64'(bus.illegal), 1);
`endif

    // zero / branch gate
    drive(2'b01, 6'b0, 32'd7, 32'd7, 1'b1);
    #1 chk("br.eq.zero", 64'(bus.zero), 1);
    chk("br.eq.pc_src", 64'(bus.pc_src), 1);
    bus.branch = 1'b0;
    #1 chk("br.nobranch.pc_src", 64'(bus.pc_src), 0);
    drive(2'b01, 6'b0, 32'd7, 32'd6, 1'b1);
    #1 chk("br.ne.pc_src", 64'(bus.pc_src), 0);

    // registers: capture, hold, reset
    @(negedge clock);
    bus.en = 1'b1; drive(2'b10, 6'b100000, 32'd5, 32'd3, 1'b0);
    @(posedge clock); #1 chk("reg.capture", 64'(bus.result_q), 8);
    @(negedge clock);
    bus.en = 1'b0; bus.A = 32'd100;
    @(posedge clock); #1 chk("reg.hold", 64'(bus.result_q), 8);
    @(negedge clock);
    bus.en = 1'b1; drive(2'b01, 6'b0, 32'd4, 32'd4, 1'b1);
    @(posedge clock); #1 chk("reg.zero_q", 64'(bus.zero_q), 1);
    chk("reg.pc_src_q", 64'(bus.pc_src_q), 1);
    @(negedge clock);
    reset = 1'b0; drive(2'b10, 6'b100000, 32'd100, 32'd3, 1'b0);
    @(posedge clock); #1;
    chk("reg.rst.result_q", 64'(bus.result_q), 0);
    chk("reg.rst.zero_q",   64'(bus.zero_q),   0);
    chk("reg.rst.pc_src_q", 64'(bus.pc_src_q), 0);
    chk("reg.rst.comb",     64'(bus.ALU_result), 103);
    @(negedge clock);
    reset = 1'b1;
    m_res_q = '0; m_zero_q = 1'b0; m_pc_q = 1'b0;

    // randomized
    for (int i = 0; i < 300; i++) begin
      logic [WIDTH-1:0] a, b;
      logic [5:0]       f;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 3) - 2;
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fsel[$urandom_range(0, 7)];
      drive(2'($urandom), f, a, b, 1'($urandom));
      bus.en = 1'($urandom);
      reset  = ($urandom_range(0, 15) != 0);
      #1 check_comb("rnd", e_res, e_zero, e_pc);
      if (!reset) begin m_res_q = '0; m_zero_q = 1'b0; m_pc_q = 1'b0; end
      else if (bus.en) begin m_res_q = e_res; m_zero_q = e_zero; m_pc_q = e_pc; end
      @(posedge clock); #1;
      chk("rnd.result_q", 64'(bus.result_q), 64'(m_res_q));
      chk("rnd.zero_q",   64'(bus.zero_q),   64'(m_zero_q));
      chk("rnd.pc_src_q", 64'(bus.pc_src_q), 64'(m_pc_q));
      @(negedge clock);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage datapath block for the single-cycle MIPS core. Decodes the 2-bit main-control ALU opcode and the R-type `funct` field into a 3-bit ALU control code. Performs the selected 32-bit operation and flags a zero result. Gates the branch signal with that flag to produce the PC-source select. Combinational outputs feed the single-cycle datapath; a registered copy of the result/flags serves debug and pipelined reuse.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width.

Ports:
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
- `en`  in  1  enables capture into the registered outputs.
- `ALUop`  in  2  main-control ALU opcode.
- `funct`  in  6  instruction[5:0].
- `A`  in  WIDTH  operand A (rs).
- `B`  in  WIDTH  operand B (rt or sign-extended immediate).
- `branch`  in  1  branch instruction flag.
- `ALU_control`  out  3  decoded control code, combinational.
- `ALU_result`  out  WIDTH  operation result, combinational.
- `zero`  out  1  `ALU_result == 0`, combinational.
- `pc_src`  out  1  `branch & zero`, combinational.
- `illegal`  out  1  `ALUop=10` with an unrecognised `funct`, combinational.
- `result_q`  out  WIDTH  registered `ALU_result`.
- `zero_q`  out  1  registered `zero`.
- `pc_src_q`  out  1  registered `pc_src`.

## Operation
Decoder:
- `ALUop=00` → 010 (add, lw/sw/addi); `funct` ignored.
- `ALUop=01` → 110 (sub, beq); `funct` ignored.
- `ALUop=10` (R-type), by `funct`:
  - 100000 → 010
  - 100010 → 110
  - 100100 → 000
  - 100101 → 001
  - 101010 → 111
  - any other `funct` → 010 and `illegal=1`.
- `ALUop=11` → 010; `illegal=0`.

ALU:
- 000 `A&B`; 001 `A|B`; 010 `A+B`; 110 `A-B`. Add/sub wrap modulo 2^WIDTH; no carry or overflow output.
- 111 SLT: result is 1 if `$signed(A) < $signed(B)`, else 0. Zero-extended to WIDTH.
- Codes 011, 100, 101 produce result 0 unless `ALU_EXT_OPS_EN` is defined (see Configuration).
- `zero` is derived from the final result for every code, including SLT.

Branch gate: `pc_src = branch & zero`.

## Timing
- `ALU_control`, `ALU_result`, `zero`, `pc_src`, `illegal`: purely combinational, zero latency, no clock dependence.
- Registered outputs, on each rising `clock`:
  - If `reset==0`: `result_q=0`, `zero_q=0`, `pc_src_q=0`. Reset has priority over `en`.
  - Else if `en==1`: capture the combinational values (1-cycle latency).
  - Else: hold.
- Reset asserted mid-operation clears the registers on the next edge only. Combinational outputs are unaffected by reset.
- No X propagation is permitted from an unused `funct` when `ALUop` is 00 or 01.

## Configuration
- `ALU_EXT_OPS_EN` defined:
  - Decoder additionally maps `funct` 100110 → 011 (XOR, `A^B`) and 100111 → 100 (NOR, `~(A|B)`). Neither sets `illegal`.
  - Code 101 still yields 0.
- Not defined: those `funct` values are illegal (→ 010, `illegal=1`), and codes 011/100 yield 0.

## Structure
- Shared package holds:
  - 3-bit ALU control localparams: `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLT`, `ALU_XOR`, `ALU_NOR`.
  - 2-bit `ALUop` constants.
  - 6-bit `funct` constants.
- One sub-module, `alu_decoder`, containing the combinational `ALUop`/`funct` → control logic (including the `illegal` flag). The ALU datapath, branch gate and output registers live in the top.

## Test plan
- Decoder: `ALUop=00`, `funct`=X → `ALU_control`=010. `ALUop=01` → 110. `ALUop=10`, `funct`=100000 → 010; `funct`=101010 → 111; `funct`=111111 → 010 with `illegal=1`.
- ALU with A=5, B=3: ctrl 000 → 1, 001 → 7, 010 → 8, 110 → 2, 111 → 0. A=−1, B=0, ctrl 111 → 1 (signed compare).
- Zero/branch: A=B=7, ctrl 110 → result 0, `zero=1`; `branch=1` → `pc_src=1`; `branch=0` → `pc_src=0`. A=7, B=6 with `branch=1` → `pc_src=0`.
- Wrap: A=32'hFFFF_FFFF, B=1, ctrl 010 → 0 with `zero=1`. A=0, B=1, ctrl 110 → 32'hFFFF_FFFF.
- Registers: with `en=1`, A=5, B=3, ctrl 010 → `result_q`=8 one edge later. Drop `en` and change A → `result_q` holds 8. Drive `reset=0` for one edge → `result_q`, `zero_q`, `pc_src_q` all 0, while combinational `ALU_result` is still valid.
- With `ALU_EXT_OPS_EN`: A=5, B=3, `funct`=100110 → 6; `funct`=100111 → 32'hFFFF_FFF8; `illegal=0` for both.
